// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Grant encoding is one-hot per requester; GRANT_NONE marks an unowned link.
package uart_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_START_WAIT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LOCKED
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? GRANT_REQ1 : GRANT_REQ0;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pointer and one-hot pick between two requesters.
// The pointer moves to the other requester whenever the current owner ends its frame.
module uart_rr_pick
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_release,
    input  logic       i_owner,
    output logic [1:0] o_pick
);

    logic r_ptr;
    logic w_other;

    assign w_other = ~r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_release) begin
            r_ptr <= ~i_owner;
        end
    end

    // Pointer holder wins a tie; a lone requester is served regardless of pointer.
    always_comb begin
        o_pick = GRANT_NONE;
        if (i_valid[r_ptr]) begin
            o_pick = owner_onehot(r_ptr);
        end else if (i_valid[w_other]) begin
            o_pick = owner_onehot(w_other);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte-stream requesters onto one UART transmitter, holding the
// link for a requester until its frame's last byte has been transmitted.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int START_WAIT = DEF_START_WAIT,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [1:0]        grant,
    output logic              err_timeout,
    output logic [15:0]       byte_count
);

    localparam int CNT_W = (START_WAIT < 2) ? 1 : $clog2(START_WAIT + 1);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_last;
    logic [1:0]        r_grant;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_err;
    logic [15:0]       r_byte_count;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic [1:0]        w_pick;
    logic              w_owner_valid;
    logic              w_accept_idle;
    logic              w_accept_lock;
    logic              w_accept;
    logic              w_sel;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;
    logic              w_timeout;
    logic              w_byte_done;
    logic              w_release;

    uart_rr_pick u_pick (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   ({req1_valid, req0_valid}),
        .i_release (w_release),
        .i_owner   (r_owner),
        .o_pick    (w_pick)
    );

    // Accepting only while the transmitter is idle keeps tx_start away from tx_busy.
    assign w_owner_valid = r_owner ? req1_valid : req0_valid;
    assign w_accept_idle = !rst && !tx_busy && (r_state == S_IDLE) && (w_pick != GRANT_NONE);
    assign w_accept_lock = !rst && !tx_busy && (r_state == S_LOCKED) && w_owner_valid;
    assign w_accept      = w_accept_idle || w_accept_lock;
    assign w_sel         = (r_state == S_LOCKED) ? r_owner : w_pick[1];
    assign w_sel_data    = w_sel ? req1_data : req0_data;
    assign w_sel_last    = w_sel ? req1_last : req0_last;

    assign req0_ready = w_accept && !w_sel;
    assign req1_ready = w_accept && w_sel;

    // The wait counter already holds 1 in the first WAIT_BUSY cycle after tx_start.
    assign w_timeout   = (r_wait_cnt >= CNT_W'(START_WAIT - 1));
    assign w_byte_done = !tx_busy &&
                         ((r_state == S_WAIT_DONE) || ((r_state == S_WAIT_BUSY) && w_timeout));
    assign w_release   = w_byte_done && r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b0;
            r_grant      <= GRANT_NONE;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_err        <= 1'b0;
            r_byte_count <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE, S_LOCKED: begin
                    if (w_accept) begin
                        r_tx_data  <= w_sel_data;
                        r_last     <= w_sel_last;
                        r_owner    <= w_sel;
                        r_grant    <= owner_onehot(w_sel);
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_byte_count <= r_byte_count + 16'd1;
                    r_wait_cnt   <= CNT_W'(1);
                    r_state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A timed-out byte finishes exactly like a transmitted one.
            if (w_byte_done) begin
                r_wait_cnt <= '0;
                if (r_last) begin
                    r_grant <= GRANT_NONE;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_LOCKED;
                end
            end
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant       = r_grant;
    assign err_timeout = r_err;
    assign byte_count  = r_byte_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single-byte frames plus
// hand sequences for ties, locked frames, timeout, mid-frame reset and count wrap.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_last, req1_valid, req1_last;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        tx_start, tx_busy, err_timeout;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic [15:0] byte_count;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] log_q[$];
    bit         hs0, hs1, prev_start, start_seen;
    bit         model_on = 1'b1;
    bit         model_kill = 1'b0;
    int         busy_delay = 2;
    int         busy_hold = 10;

    typedef struct {
        bit          req;
        logic [7:0]  data;
        logic [1:0]  exp_grant;
        logic [15:0] exp_count;
    } vec_t;
    vec_t vecs[6];

    uart_tx_arbiter #(.START_WAIT(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .err_timeout (err_timeout),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic void push(input bit r, input logic [7:0] d, input logic l);
        if (r) q1.push_back({l, d});
        else   q0.push_back({l, d});
    endfunction

    function automatic bit quiet();
        return (grant == 2'b00) && !tx_busy && (q0.size() == 0) && (q1.size() == 0)
               && !req0_valid && !req1_valid;
    endfunction

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while ((log_q.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        if (log_q.size() < n) chk({name, "_start_timeout"}, log_q.size(), n);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int k = 0;
        while (!quiet() && (k < budget)) begin
            tick();
            k++;
        end
        if (!quiet()) chk({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic chk_log(input int i, input logic [7:0] d, input logic [1:0] g, input string name);
        if (log_q.size() > i) begin
            chk({name, "_data"}, log_q[i][7:0], d);
            chk({name, "_grant"}, log_q[i][9:8], g);
        end else begin
            chk({name, "_missing"}, log_q.size(), i + 1);
        end
    endtask

    // Requester driver: handshake sampled just before the edge, next byte presented after it.
    initial begin
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (hs0 && (q0.size() > 0)) void'(q0.pop_front());
            if (hs1 && (q1.size() > 0)) void'(q1.pop_front());
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_last, req0_data} = q0[0];
            end else begin
                req0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_last, req1_data} = q1[0];
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // Transmitter model: busy rises busy_delay cycles after the tx_start cycle, held busy_hold cycles.
    always @(negedge clk) start_seen = tx_start && model_on;

    initial begin
        int dl = 0;
        int hl = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (model_kill) begin
                tx_busy = 1'b0; dl = 0; hl = 0;
            end else if (dl > 0) begin
                dl--;
                if (dl == 0) begin tx_busy = 1'b1; hl = busy_hold; end
            end else if (hl > 0) begin
                hl--;
                if (hl == 0) tx_busy = 1'b0;
            end else if (start_seen) begin
                if (busy_delay <= 1) begin tx_busy = 1'b1; hl = busy_hold; end
                else dl = busy_delay - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) log_q.push_back({grant, tx_data});
            if (tx_start && (prev_start || tx_busy)) viol++;
            if (req0_ready && req1_ready) viol++;
            if (req0_ready && (grant == GRANT_REQ1)) viol++;
            if (req1_ready && (grant == GRANT_REQ0)) viol++;
        end
        prev_start = tx_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h41, GRANT_REQ0, 16'd1};
        vecs[1] = '{1'b0, 8'h42, GRANT_REQ0, 16'd2};
        vecs[2] = '{1'b1, 8'h7E, GRANT_REQ1, 16'd3};
        vecs[3] = '{1'b1, 8'h80, GRANT_REQ1, 16'd4};
        vecs[4] = '{1'b0, 8'hFF, GRANT_REQ0, 16'd5};
        vecs[5] = '{1'b0, 8'h00, GRANT_REQ0, 16'd6};

        repeat (3) tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_count", byte_count, 16'h0000);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            log_q.delete();
            push(vecs[i].req, vecs[i].data, 1'b1);
            wait_log(1, 40, $sformatf("vec%0d", i));
            chk_log(0, vecs[i].data, vecs[i].exp_grant, $sformatf("vec%0d", i));
            wait_quiet(80, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), byte_count, vecs[i].exp_count);
            chk($sformatf("vec%0d_grant_released", i), grant, 2'b00);
            chk($sformatf("vec%0d_tx_data_hold", i), tx_data, vecs[i].data);
            chk($sformatf("vec%0d_one_start", i), log_q.size(), 1);
        end

        // Tie after reset, then alternation over four frames.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        log_q.delete();
        push(0, 8'h11, 1'b1); push(0, 8'h33, 1'b1);
        push(1, 8'h22, 1'b1); push(1, 8'h44, 1'b1);
        wait_log(4, 200, "rr");
        wait_quiet(80, "rr");
        chk_log(0, 8'h11, GRANT_REQ0, "rr0");
        chk_log(1, 8'h22, GRANT_REQ1, "rr1");
        chk_log(2, 8'h33, GRANT_REQ0, "rr2");
        chk_log(3, 8'h44, GRANT_REQ1, "rr3");
        chk("rr_count", byte_count, 16'd4);

        // Locked three-byte frame while the other requester waits.
        log_q.delete();
        push(0, 8'hA5, 1'b0); push(0, 8'h5A, 1'b0); push(0, 8'h0D, 1'b1);
        push(1, 8'h77, 1'b1);
        wait_log(4, 200, "lock");
        wait_quiet(80, "lock");
        chk_log(0, 8'hA5, GRANT_REQ0, "lock0");
        chk_log(1, 8'h5A, GRANT_REQ0, "lock1");
        chk_log(2, 8'h0D, GRANT_REQ0, "lock2");
        chk_log(3, 8'h77, GRANT_REQ1, "lock3");
        chk("lock_count", byte_count, 16'd8);

        // Transmitter never goes busy: timeout lands 8 cycles after the tx_start cycle.
        model_on = 1'b0;
        log_q.delete();
        push(0, 8'h99, 1'b1);
        wait_log(1, 40, "tmo");
        repeat (7) tick();
        chk("tmo_not_yet", err_timeout, 1'b0);
        tick();
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_grant", grant, 2'b00);
        repeat (5) tick();
        chk("tmo_sticky", err_timeout, 1'b1);
        chk("tmo_count", byte_count, 16'd9);
        model_on = 1'b1;
        log_q.delete();
        push(1, 8'h55, 1'b1);
        wait_log(1, 40, "post_tmo");
        chk_log(0, 8'h55, GRANT_REQ1, "post_tmo");
        wait_quiet(80, "post_tmo");
        chk("post_tmo_err", err_timeout, 1'b1);

        // Reset while a locked frame sits in WAIT_DONE.
        log_q.delete();
        push(0, 8'h10, 1'b0); push(0, 8'h20, 1'b0); push(0, 8'h30, 1'b1);
        wait_log(2, 80, "midrst");
        begin
            int k = 0;
            while (!tx_busy && (k < 20)) begin tick(); k++; end
            if (!tx_busy) chk("midrst_busy_timeout", 0, 1);
        end
        tick();
        rst = 1'b1;
        model_kill = 1'b1;
        q0.delete();
        push(1, 8'h5C, 1'b1);
        tick();
        chk("midrst_grant", grant, 2'b00);
        chk("midrst_tx_start", tx_start, 1'b0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_err", err_timeout, 1'b0);
        chk("midrst_count", byte_count, 16'h0000);
        chk("midrst_ready_in_rst", {req1_ready, req0_ready}, 2'b00);
        rst = 1'b0;
        model_kill = 1'b0;
        log_q.delete();
        #1;
        chk("midrst_first_ready", {req1_ready, req0_ready}, 2'b10);
        wait_log(1, 2, "midrst_next");
        chk_log(0, 8'h5C, GRANT_REQ1, "midrst_next");
        wait_quiet(80, "midrst_next");
        chk("midrst_next_count", byte_count, 16'd1);

        // Counter wrap: preload near the top, then issue two bytes.
        busy_delay = 1;
        busy_hold  = 1;
        force dut.r_byte_count = 16'hFFFE;
        tick();
        release dut.r_byte_count;
        push(0, 8'hE1, 1'b1);
        wait_log(1, 40, "wrap1");
        wait_quiet(40, "wrap1");
        chk("wrap_ffff", byte_count, 16'hFFFF);
        push(0, 8'hE2, 1'b0);
        push(0, 8'hE3, 1'b1);
        wait_log(3, 60, "wrap2");
        wait_quiet(40, "wrap2");
        chk("wrap_0001", byte_count, 16'h0001);

        chk("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: START_WAIT, 8, max cycles from tx_start to tx_busy rising before timeout.
REQ-002 Parameter: DATA_W, 8, byte width.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: req0_valid/req1_valid  in  1 each  requester has a byte.
REQ-006 Ports: req0_data/req1_data  in  DATA_W each  requester byte.
REQ-007 Ports: req0_last/req1_last  in  1 each  byte ends the requester's frame.
REQ-008 Ports: req0_ready/req1_ready  out  1 each  byte accepted this cycle when valid&ready.
REQ-009 Port: tx_start  out  1  one-cycle start pulse to UART transmitter.
REQ-010 Port: tx_data  out  DATA_W  byte to transmit; registered.
REQ-011 Port: tx_busy  in  1  transmitter busy.
REQ-012 Port: grant  out  2  one-hot current owner; 00 when unowned.
REQ-013 Port: err_timeout  out  1  sticky; tx_busy failed to rise.
REQ-014 Port: byte_count  out  16  bytes issued since reset.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, LOCKED.
REQ-016 IDLE: when tx_busy=0 and any valid, SHALL select owner (round-robin pointer preferred on tie), assert that reqN_ready for exactly one cycle, latch data and last, set grant, go START.
REQ-017 IDLE with tx_busy=1 SHALL assert no ready and stay.
REQ-018 START: tx_start=1 for one cycle with tx_data stable; byte_count increments; go WAIT_BUSY.
REQ-019 WAIT_BUSY: on tx_busy=1 go WAIT_DONE; if START_WAIT cycles elapse without it, set err_timeout and proceed as if the byte completed.
REQ-020 WAIT_DONE: on tx_busy=0, if latched last=1 release grant to 00, set pointer to the other requester, go IDLE; else go LOCKED.
REQ-021 LOCKED: only the owner is served; owner valid -> owner ready one cycle, latch, go START; the other requester's valid SHALL be ignored.
REQ-022 At most one ready SHALL be high per cycle; never in START, WAIT_BUSY or WAIT_DONE.
REQ-023 tx_start SHALL never assert while tx_busy=1 or in two consecutive cycles.
REQ-024 tx_data SHALL hold the last issued byte until the next accept.
REQ-025 byte_count SHALL wrap 0xFFFF -> 0x0000.
REQ-026 Both requesters valid in IDLE: pointer owner wins; loser's valid waits, is not dropped.
REQ-027 Single requester valid SHALL be served regardless of pointer.

Reset
REQ-028 rst SHALL, in any state including mid-frame, force IDLE, pointer=0, grant=00, tx_start=0, tx_data=0, ready=0, err_timeout=0, byte_count=0, timeout counter=0.
REQ-029 First cycle after rst deasserts SHALL be able to accept a byte.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, DATA_W default and the owner/grant encoding constants.
REQ-031 One sub-module, uart_rr_pick (pointer register plus one-hot pick), is natural; the remainder stays in uart_tx_arbiter.

Verification
REQ-032 req0 single byte 0x41 last=1, tx_busy rises 2 cycles after start, held 10 -> one tx_start, tx_data=0x41, grant 01 then 00, byte_count=1.
REQ-033 Both valid in IDLE after reset (req0=0x11, req1=0x22, both last=1) -> 0x11 sent first, then 0x22; pointer alternation verified over 4 frames.
REQ-034 req0 frame 0xA5,0x5A,0x0D (last on third) with req1 valid throughout -> three req0 bytes contiguous, req1 served only after grant returns to 00.
REQ-035 tx_busy held 0 after start, START_WAIT=8 -> err_timeout=1 at cycle 8 and stays 1; FSM returns to IDLE.
REQ-036 rst pulsed during WAIT_DONE of a locked frame -> all outputs at reset values next cycle; next req1 byte served immediately.
REQ-037 Preload 0xFFFF sends via 65535 bytes, then one more -> byte_count=0x0000; no double tx_start observed throughout.
